// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 DVP capture path: capture FSM states,
// default frame geometry and the frame pixel-count helper.
package ov7670_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2
  } cap_state_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Number of framebuffer words one frame occupies (quartered when decimating).
  function automatic int frame_pixels(input int h, input int v, input bit decim);
    return decim ? (h / 2) * (v / 2) : h * v;
  endfunction

endpackage

// File: rtl/ov7670_edge_det.sv
// Registered input stage for one camera sync line plus rise/fall pulses.
// q is the single-registered copy every decision uses; rise/fall are
// combinational against a second delayed copy, so they coincide with q.
module ov7670_edge_det (
  input  logic pclk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  // Sample the pin, then keep one more stage for edge detection.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= din;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/ov7670_capture_rx.sv
// OV7670 8-bit DVP receiver in the pixel-clock domain. Pairs bytes into
// RGB565 words and emits a row-major framebuffer write stream; flags frames
// whose line lengths, line count or address range were wrong.
// Optional: define OV7670_CAPTURE_DECIM2_EN for 2:1 decimation in both axes
// (even pixels of even lines only, quarter-size address range).
module ov7670_capture_rx
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic              cap_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err
);

`ifdef OV7670_CAPTURE_DECIM2_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  localparam int            FRAME_PIX  = frame_pixels(H_ACTIVE, V_ACTIVE, DECIM);
  // One extra address bit so the limit is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(FRAME_PIX);
  localparam logic [ADDR_W:0] ADDR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [15:0]     H_LEN      = 16'(H_ACTIVE);
  localparam logic [15:0]     V_LEN      = 16'(V_ACTIVE);

  cap_state_e        state;
  logic              vsync_q, vsync_rise, vsync_fall;
  logic              href_q, href_rise, href_fall;
  logic [7:0]        d_q, hi_byte;
  logic              phase;
  logic              line_open;
  logic [15:0]       line_pix, line_cnt;
  logic              err_acc;
  logic [ADDR_W:0]   addr;

  logic              px_valid, keep_pix, line_end, line_bad;
  logic [15:0]       lines_next;

  ov7670_edge_det u_vsync_det (
    .pclk (pclk),
    .rst  (rst),
    .din  (vsync),
    .q    (vsync_q),
    .rise (vsync_rise),
    .fall (vsync_fall)
  );

  ov7670_edge_det u_href_det (
    .pclk (pclk),
    .rst  (rst),
    .din  (href),
    .q    (href_q),
    .rise (href_rise),
    .fall (href_fall)
  );

  // Data byte gets the same single register stage as the sync lines.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) d_q <= 8'h00;
    else     d_q <= d;
  end

  // Per-cycle qualifiers: a byte only counts inside a line that opened while
  // ACTIVE with vsync low, so a line already running at frame start is dropped.
  always_comb begin
    px_valid   = (state == ACTIVE) && href_q && !vsync_q && (line_open || href_rise);
    line_end   = (state == ACTIVE) && href_fall && line_open;
    line_bad   = (line_pix != H_LEN) || phase;
    lines_next = (line_end && (line_cnt != 16'hFFFF)) ? line_cnt + 16'd1 : line_cnt;
    keep_pix   = 1'b1;
    if (DECIM) keep_pix = ~line_cnt[0] & ~line_pix[0];
  end

  // Capture FSM with registered write port and frame status.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 16'h0000;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      hi_byte    <= 8'h00;
      phase      <= 1'b0;
      line_open  <= 1'b0;
      line_pix   <= 16'h0000;
      line_cnt   <= 16'h0000;
      err_acc    <= 1'b0;
      addr       <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (vsync_rise) state <= VBLANK;
        end

        VBLANK: begin
          if (vsync_fall) begin
            if (cap_en) begin
              state     <= ACTIVE;
              addr      <= '0;
              phase     <= 1'b0;
              line_open <= 1'b0;
              line_pix  <= 16'h0000;
              line_cnt  <= 16'h0000;
              err_acc   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end

        ACTIVE: begin
          if (href_rise && !vsync_q) line_open <= 1'b1;

          if (px_valid) begin
            phase <= ~phase;
            if (!phase) begin
              hi_byte <= d_q;
            end else begin
              if (line_pix != 16'hFFFF) line_pix <= line_pix + 16'd1;
              if (keep_pix) begin
                if (addr == ADDR_LIMIT) begin
                  // Frame longer than the buffer: drop the pixel, hold addr.
                  err_acc <= 1'b1;
                end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr[ADDR_W-1:0];
                  wr_data <= {hi_byte, d_q};
                  addr    <= addr + ADDR_ONE;
                end
              end
            end
          end

          // Any href drop realigns the byte pairing for the next line.
          if (href_fall) phase <= 1'b0;

          if (line_end) begin
            line_open <= 1'b0;
            line_pix  <= 16'h0000;
            line_cnt  <= lines_next;
            if (line_bad) err_acc <= 1'b1;
          end

          // Frame end; a line ending on this same cycle is folded in.
          if (vsync_rise) begin
            frame_done <= 1'b1;
            frame_err  <= err_acc | (line_end & line_bad) | (lines_next != V_LEN);
            state      <= VBLANK;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture_rx.sv
// Scoreboard bench for ov7670_capture_rx on a reduced 4x4 geometry. The
// stimulus pushes expected writes (addr, data, cycle) and frame status; a
// monitor pops them whenever wr_en or frame_done is seen.
module tb_ov7670_capture_rx;

  localparam int H  = 4;
  localparam int V  = 4;
  localparam int AW = 5;
`ifdef OV7670_CAPTURE_DECIM2_EN
  localparam bit DEC   = 1'b1;
  localparam int LIMIT = (H / 2) * (V / 2);
`else
  localparam bit DEC   = 1'b0;
  localparam int LIMIT = H * V;
`endif

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    d = 8'h00;
  logic          cap_en = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic          frame_err;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            cyc;
  } wr_t;

  wr_t wq[$];
  bit  eq[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  seed = 1;
  bit  special = 1'b0;

  ov7670_capture_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .cap_en     (cap_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge pclk) begin
    wr_t e;
    bit  ee;
    if (wr_en) begin
      if (wq.size() == 0) begin
        check(1'b0, "spurious_wr_addr", 64'(wr_addr), 64'hFFFF);
      end else begin
        e = wq.pop_front();
        check(wr_addr == e.addr, "wr_addr", 64'(wr_addr), 64'(e.addr));
        check(wr_data == e.data, "wr_data", 64'(wr_data), 64'(e.data));
        check(cyc == e.cyc, "wr_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (frame_done) begin
      if (eq.size() == 0) begin
        check(1'b0, "spurious_frame_done", 64'(frame_err), 64'hFFFF);
      end else begin
        ee = eq.pop_front();
        check(frame_err == ee, "frame_err", 64'(frame_err), 64'(ee));
      end
    end
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] b);
    @(negedge pclk);
    vsync = v;
    href  = h;
    d     = b;
  endtask

  task automatic reset_checks(input string tag);
    check(wr_en == 1'b0, {tag, "_wr_en"}, 64'(wr_en), 64'h0);
    check(wr_addr == '0, {tag, "_wr_addr"}, 64'(wr_addr), 64'h0);
    check(wr_data == 16'h0, {tag, "_wr_data"}, 64'(wr_data), 64'h0);
    check(frame_done == 1'b0, {tag, "_frame_done"}, 64'(frame_done), 64'h0);
    check(frame_err == 1'b0, {tag, "_frame_err"}, 64'(frame_err), 64'h0);
  endtask

  // One frame: vsync pulse, then nlines of HREF. short_l shortens one line by
  // a byte; abort_l pulses rst three bytes into that line.
  task automatic send_frame(input bit cap, input int short_l, input int nlines, input int abort_l);
    int  exp_addr;
    bit  live, ovf, keep;
    int  nb;
    logic [7:0] hi, lo;
    hi = 8'h00;
    lo = 8'h00;
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    cap_en   = cap;
    exp_addr = 0;
    live     = cap;
    ovf      = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < nlines; l++) begin
      if (l == nlines / 2) cap_en = ~cap;
      nb = (l == short_l) ? 2 * H - 1 : 2 * H;
      for (int b = 0; b < nb; b++) begin
        if (l == abort_l && b == 3) begin
          @(negedge pclk);
          #2 rst = 1'b1;
          #1 reset_checks("async_reset");
          @(negedge pclk);
          rst  = 1'b0;
          live = 1'b0;
        end
        if (b % 2 == 0) begin
          if (special && l == 0 && b == 0) begin
            hi = 8'hA5;
            lo = 8'h3C;
          end else begin
            hi = 8'(seed);
            lo = 8'(seed * 7 + 3);
          end
          seed++;
        end
        drive(1'b0, 1'b1, (b % 2 == 0) ? hi : lo);
        if (b % 2 == 1 && live) begin
          keep = !DEC || ((l % 2 == 0) && ((b / 2) % 2 == 0));
          if (keep) begin
            if (exp_addr < LIMIT) begin
              wq.push_back('{AW'(exp_addr), {hi, lo}, cyc + 2});
              exp_addr++;
            end else begin
              ovf = 1'b1;
            end
          end
        end
      end
      repeat (3) drive(1'b0, 1'b0, 8'h00);
    end
    if (live) eq.push_back(ovf || (short_l >= 0 && short_l < nlines) || (nlines != V));
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    #1 reset_checks("reset");
    @(negedge pclk);
    rst = 1'b0;

    // Data before the first VSYNC must be discarded.
    cap_en = 1'b1;
    for (int b = 0; b < 2 * H; b++) drive(1'b0, 1'b1, 8'(b + 8'h40));
    repeat (3) drive(1'b0, 1'b0, 8'h00);

    special = 1'b1;
    send_frame(1'b1, -1, V, -1);     // clean, first pixel 0xA53C
    special = 1'b0;
    send_frame(1'b1, 2, V, -1);      // short line -> error
    send_frame(1'b1, -1, V, -1);     // clean again, cap_en toggled mid-frame
    send_frame(1'b0, -1, V, -1);     // not captured
    send_frame(1'b1, -1, V, -1);     // resumes at addr 0
    send_frame(1'b1, -1, V + 1, -1); // extra line -> overflow and error
    send_frame(1'b1, -1, V, 1);      // reset mid-line
    send_frame(1'b1, -1, V, -1);     // first frame after reset, addr 0
    cap_en = 1'b0;
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    repeat (4) drive(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 20 && (wq.size() != 0 || eq.size() != 0); i++) @(negedge pclk);
    check(wq.size() == 0, "writes_outstanding", 64'(wq.size()), 64'h0);
    check(eq.size() == 0, "frames_outstanding", 64'(eq.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
